// File: rtl/uart_cmd_host.sv
// UART command host: sends opcode/addr 8N1, then collects a fixed-length reply.
// Optional: UART_HOST_CHECKSUM_EN adds an XOR checksum byte in each direction.
module uart_cmd_host #(
  parameter int DELAY_FRAMES   = 234,
  parameter int RESP_BYTES     = 2,
  parameter int TIMEOUT_CYCLES = 2_700_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_opcode,
  input  logic [7:0]              req_addr,
  output logic                    resp_valid,
  output logic [8*RESP_BYTES-1:0] resp_data,
  output logic                    resp_error,
  output logic                    busy,
  output logic                    uart_tx,
  input  logic                    uart_rx
);

`ifdef UART_HOST_CHECKSUM_EN
  localparam int NTX = 3;
  localparam int NRX = RESP_BYTES + 1;
`else
  localparam int NTX = 2;
  localparam int NRX = RESP_BYTES;
`endif

  localparam int CW = $clog2(DELAY_FRAMES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(NRX + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(DELAY_FRAMES - 1);
  localparam logic [CW-1:0] HALF     = CW'(DELAY_FRAMES / 2 - 1);
  localparam logic [TW-1:0] TMO      = TW'(TIMEOUT_CYCLES);
  localparam logic [1:0]    TX_LAST  = 2'(NTX - 1);
  localparam logic [RW-1:0] RX_LAST  = RW'(NRX - 1);

  typedef enum logic [2:0] {
    IDLE, TX_BYTE, RX_WAIT, RX_BYTE, DONE
  } state_t;

  state_t        state;
  logic [7:0]    op_q;
  logic [7:0]    addr_q;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [1:0]    tx_idx;
  logic [RW-1:0] rx_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    shift;
  logic          rx_s1, rx_s2, rx_prev;
  logic [7:0]    tx_byte;
  logic [9:0]    tx_frame;
  logic          rx_fall;
`ifdef UART_HOST_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // Select the byte currently being serialised
  always_comb begin
    tx_byte = op_q;
    unique case (1'b1)
      tx_idx == 2'd1: tx_byte = addr_q;
`ifdef UART_HOST_CHECKSUM_EN
      tx_idx == 2'd2: tx_byte = op_q ^ addr_q;
`endif
      default: ;
    endcase
  end

  assign tx_frame = {1'b1, tx_byte, 1'b0};
  assign rx_fall  = rx_prev & ~rx_s2;

  // Two-flop synchroniser plus delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      tx_idx     <= '0;
      rx_cnt     <= '0;
      tmo_cnt    <= '0;
      shift      <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
      busy       <= 1'b0;
      uart_tx    <= 1'b1;
`ifdef UART_HOST_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          uart_tx   <= 1'b1;
          if (req_valid && req_ready) begin
            op_q       <= req_opcode;
            addr_q     <= req_addr;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            resp_data  <= '0;
            resp_error <= 1'b0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            tx_idx     <= '0;
            rx_cnt     <= '0;
            tmo_cnt    <= '0;
`ifdef UART_HOST_CHECKSUM_EN
            csum       <= '0;
`endif
            state      <= TX_BYTE;
          end
        end
        TX_BYTE: begin
          uart_tx <= tx_frame[bit_idx];
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              if (tx_idx == TX_LAST) state <= RX_WAIT;
              else tx_idx <= tx_idx + 2'd1;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        RX_WAIT: begin
          uart_tx <= 1'b1;
          if (tmo_cnt == TMO) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (rx_fall) begin
              state   <= RX_BYTE;
              clk_cnt <= '0;
              bit_idx <= '0;
            end
          end
        end
        RX_BYTE: begin
          if (bit_idx == 4'd0) begin
            // Mid-start re-check filters short glitches
            if (clk_cnt == HALF) begin
              clk_cnt <= '0;
              if (rx_s2) state <= RX_WAIT;
              else bit_idx <= 4'd1;
            end else begin
              clk_cnt <= clk_cnt + CW'(1);
            end
          end else if (clk_cnt != BIT_LAST) begin
            clk_cnt <= clk_cnt + CW'(1);
          end else begin
            clk_cnt <= '0;
            if (bit_idx != 4'd9) begin
              shift   <= {rx_s2, shift[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end else begin
              for (int k = 0; k < RESP_BYTES; k++)
                if (rx_cnt == RW'(k))
                  resp_data[8*k +: 8] <= shift;
              bit_idx <= '0;
              if (!rx_s2) begin
                state      <= DONE;
                resp_valid <= 1'b1;
                resp_error <= 1'b1;
              end else begin
`ifdef UART_HOST_CHECKSUM_EN
                csum <= csum ^ shift;
                if (rx_cnt == RX_LAST && shift != csum)
                  resp_error <= 1'b1;
`endif
                rx_cnt  <= rx_cnt + RW'(1);
                tmo_cnt <= '0;
                if (rx_cnt == RX_LAST) begin
                  state      <= DONE;
                  resp_valid <= 1'b1;
                end else begin
                  state <= RX_WAIT;
                end
              end
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host: TX framing, replies, timeout,
// glitch/framing error, async reset mid-frame, optional checksum.
module tb_uart_cmd_host;

  localparam int DF  = 8;
  localparam int TMO = 200;
  localparam int RB  = 2;
`ifdef UART_HOST_CHECKSUM_EN
  localparam int NTX = 3;
`else
  localparam int NTX = 2;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_opcode, req_addr;
  logic        resp_valid, resp_error, busy;
  logic [15:0] resp_data;
  logic        uart_tx, uart_rx;

  uart_cmd_host #(
    .DELAY_FRAMES  (DF),
    .RESP_BYTES    (RB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opcode(req_opcode),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_error(resp_error),
    .busy      (busy),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int          n_resp = 0;
  logic [15:0] r_data;
  logic        r_err, r_busy;

  // Record every response pulse away from the active edge
  always @(negedge clk) begin
    if (resp_valid) begin
      n_resp++;
      r_data = resp_data;
      r_err  = resp_error;
      r_busy = busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] op,
                          input logic [7:0] ad);
    int t = 0;
    while (!req_ready && t < 100) begin
      cyc(1);
      t++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    req_opcode = op;
    req_addr   = ad;
    req_valid  = 1'b1;
    cyc(1);
    req_valid  = 1'b0;
    chk("busy_acc", 32'(busy), 32'd1);
    chk("data_clr", 32'(resp_data), 32'd0);
  endtask

  task automatic get_tx(output logic [7:0] b,
                        output logic ok);
    int t = 0;
    b  = '0;
    ok = 1'b0;
    while (uart_tx && t < 500) begin
      cyc(1);
      t++;
    end
    if (uart_tx) return;
    cyc(DF / 2);
    ok = !uart_tx;
    for (int i = 0; i < 8; i++) begin
      cyc(DF);
      b[i] = uart_tx;
    end
    cyc(DF);
    ok = ok & uart_tx;
  endtask

  task automatic check_tx(input logic [7:0] e0,
                          input logic [7:0] e1,
                          input logic [7:0] e2);
    logic [7:0] e [3];
    logic [7:0] b;
    logic       ok;
    e = '{e0, e1, e2};
    for (int i = 0; i < NTX; i++) begin
      get_tx(b, ok);
      chk($sformatf("tx_byte%0d", i),
          {23'd0, ok, b}, {23'd0, 1'b1, e[i]});
    end
  endtask

  task automatic rx_send(input logic [7:0] b,
                         input logic stop);
    uart_rx = 1'b0;
    cyc(DF);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      cyc(DF);
    end
    uart_rx = stop;
    cyc(DF);
    uart_rx = 1'b1;
  endtask

  task automatic wait_resp(input int prev,
                           output int lat);
    lat = 0;
    while (n_resp == prev && lat < 2000) begin
      cyc(1);
      lat++;
    end
    chk("resp_seen", 32'(n_resp), 32'(prev + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  int prev, lat;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_opcode = '0;
    req_addr   = '0;
    uart_rx    = 1'b1;
    cyc(3);
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_err", 32'(resp_error), 32'd0);
    rst_n = 1'b1;
    cyc(1);
    chk("ready_post_rst", 32'(req_ready), 32'd1);

    // Normal read: 0x01/0x2A, reply 0x34,0x12
    send_req(8'h01, 8'h2A);
    check_tx(8'h01, 8'h2A, 8'h2B);
    cyc(10);
    prev = n_resp;
    rx_send(8'h34, 1'b1);
    rx_send(8'h12, 1'b1);
`ifdef UART_HOST_CHECKSUM_EN
    rx_send(8'h26, 1'b1);
`endif
    wait_resp(prev, lat);
    chk("ok_data", 32'(r_data), 32'h1234);
    chk("ok_err", 32'(r_err), 32'd0);
    chk("ok_busy_pulse", 32'(r_busy), 32'd1);
    cyc(2);
    chk("ok_busy_after", 32'(busy), 32'd0);
    chk("ok_ready_after", 32'(req_ready), 32'd1);
    chk("ok_tx_idle", 32'(uart_tx), 32'd1);
    chk("ok_data_hold", 32'(resp_data), 32'h1234);

    // No reply: timeout 200 clks after last stop bit
    send_req(8'h55, 8'hC3);
    check_tx(8'h55, 8'hC3, 8'h96);
    prev = n_resp;
    wait_resp(prev, lat);
    chk("tmo_latency", 32'(lat >= 203 && lat <= 207), 32'd1);
    chk("tmo_err", 32'(r_err), 32'd1);
    chk("tmo_data", 32'(r_data), 32'd0);

    // 4-clk glitch, then 0x34 with low stop bit
    send_req(8'h80, 8'h7F);
    check_tx(8'h80, 8'h7F, 8'hFF);
    cyc(10);
    prev = n_resp;
    uart_rx = 1'b0;
    cyc(4);
    uart_rx = 1'b1;
    cyc(6);
    chk("glitch_no_resp", 32'(n_resp), 32'(prev));
    rx_send(8'h34, 1'b0);
    wait_resp(prev, lat);
    chk("frm_err", 32'(r_err), 32'd1);
    chk("frm_data", 32'(r_data), 32'h0034);
    cyc(4);

    // Async reset during second TX byte
    send_req(8'hA5, 8'h5A);
    begin
      logic [7:0] b;
      logic       ok;
      get_tx(b, ok);
      chk("rst_mid_b0", {23'd0, ok, b}, {23'd0, 1'b1, 8'hA5});
    end
    cyc(6);
    chk("rst_mid_start", 32'(uart_tx), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'(uart_tx), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    send_req(8'h01, 8'h2A);
    check_tx(8'h01, 8'h2A, 8'h2B);
    cyc(10);
    prev = n_resp;
    rx_send(8'h78, 1'b1);
    rx_send(8'h56, 1'b1);
`ifdef UART_HOST_CHECKSUM_EN
    rx_send(8'h2E, 1'b1);
`endif
    wait_resp(prev, lat);
    chk("post_rst_data", 32'(r_data), 32'h5678);
    chk("post_rst_err", 32'(r_err), 32'd0);

`ifdef UART_HOST_CHECKSUM_EN
    // Wrong checksum byte
    send_req(8'h01, 8'h2A);
    check_tx(8'h01, 8'h2A, 8'h2B);
    cyc(10);
    prev = n_resp;
    rx_send(8'h34, 1'b1);
    rx_send(8'h12, 1'b1);
    rx_send(8'h27, 1'b1);
    wait_resp(prev, lat);
    chk("csum_bad_err", 32'(r_err), 32'd1);
    chk("csum_bad_data", 32'(r_data), 32'h1234);
`endif

    cyc(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
